// File: rtl/sensor_alarm_ctrl.sv
// sensor_alarm_ctrl
//   N-channel sensor alarm controller. The lowest-index active sensor is the
//   candidate; once it has won DEBOUNCE consecutive enabled samples a one-hot
//   buzzer is raised for HOLD enabled cycles, or until ack. A saturating
//   8-bit counter records how many alarms were raised.
//
//   Optional feature macro: ALARM_RETRIGGER_EN
//     defined     - the alarming sensor, still sampled high (without ack),
//                   restarts the hold time.
//     not defined - sensor inputs are ignored while an alarm is active.
module sensor_alarm_ctrl #(
   parameter  int NUM_CH   = 3,
   parameter  int DEBOUNCE = 100,
   parameter  int HOLD     = 100000000,
   localparam int ID_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int DB_W     = $clog2(DEBOUNCE + 1),
   localparam int HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NUM_CH-1:0] sensor,
   input  logic              ack,
   output logic [NUM_CH-1:0] buzzer,
   output logic              active,
   output logic [ID_W-1:0]   alarm_id,
   output logic [7:0]        alarm_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      ALARM = 1'b1
   } state_t;

   localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

   state_t            state;
   logic [DB_W-1:0]   db_cnt;
   logic [ID_W-1:0]   stored_cand;
   logic [HOLD_W-1:0] hold_cnt;

   logic              cand_valid;
   logic [ID_W-1:0]   cand;
   logic [DB_W-1:0]   db_next;
   logic [ID_W-1:0]   cand_next;
   logic              db_hit;

   // Priority encoder: lowest-index set sensor bit wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      cand_valid = 1'b0;
      cand       = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (sensor[i]) begin
            cand_valid = 1'b1;
            cand       = ID_W'(i);
         end
      end
   end

   // Next debounce count and stored candidate for an idle sample.
   always_comb begin
      db_next   = db_cnt;
      cand_next = stored_cand;
      if (!cand_valid) begin
         db_next = '0;
      end else if (cand == stored_cand && db_cnt != '0) begin
         db_next = db_cnt + DB_W'(1);
      end else begin
         cand_next = cand;
         db_next   = DB_W'(1);
      end
      db_hit = (db_next == DB_W'(DEBOUNCE));
   end

   // Controller state machine with registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and sits outside the enable, so it acts
      // even while ena is low.
      if (!rst_n) begin
         // NOTE: state uses non-blocking assignments so every register
         // updates from the values present before the edge.
         state       <= IDLE;
         db_cnt      <= '0;
         stored_cand <= '0;
         hold_cnt    <= '0;
         buzzer      <= '0;
         active      <= 1'b0;
         alarm_id    <= '0;
         alarm_cnt   <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               stored_cand <= cand_next;
               if (db_hit) begin
                  state    <= ALARM;
                  buzzer   <= ONE_HOT0 << cand;
                  active   <= 1'b1;
                  alarm_id <= cand;
                  hold_cnt <= '0;
                  db_cnt   <= '0;
                  if (alarm_cnt != 8'hFF) begin
                     alarm_cnt <= alarm_cnt + 8'd1;
                  end
               end else begin
                  db_cnt <= db_next;
               end
            end

            ALARM: begin
               if (ack) begin
                  state  <= IDLE;
                  buzzer <= '0;
                  active <= 1'b0;
`ifdef ALARM_RETRIGGER_EN
               end else if (|(sensor & buzzer)) begin
                  // buzzer is one-hot on alarm_id, so this tests sensor[alarm_id]
                  hold_cnt <= '0;
`endif
               end else if (hold_cnt == HOLD_W'(HOLD - 1)) begin
                  state  <= IDLE;
                  buzzer <= '0;
                  active <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end

            default: begin
               state  <= IDLE;
               buzzer <= '0;
               active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// tb_sensor_alarm_ctrl
//   Scoreboard bench: the driver applies inputs on the falling edge, steps a
//   behavioural model for the following rising edge and queues the expected
//   outputs; the monitor pops and compares just after each rising edge.
//   Honours ALARM_RETRIGGER_EN the same way as the design.
module tb_sensor_alarm_ctrl;

   localparam int NUM_CH   = 3;
   localparam int DEBOUNCE = 4;
   localparam int HOLD     = 8;
   localparam int ID_W     = 2;

   typedef struct {
      logic [NUM_CH-1:0] buzzer;
      logic              active;
      logic [ID_W-1:0]   alarm_id;
      logic [7:0]        alarm_cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ena;
   logic [NUM_CH-1:0] sensor;
   logic              ack;
   logic [NUM_CH-1:0] buzzer;
   logic              active;
   logic [ID_W-1:0]   alarm_id;
   logic [7:0]        alarm_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t exp_q[$];

   // Reference model state: run length of the current winning sensor,
   // remaining alarm edges, and the alarm bookkeeping.
   int m_run      = 0;
   int m_last     = 0;
   bit m_alarm    = 1'b0;
   int m_left     = 0;
   int m_ch       = 0;
   int m_cnt      = 0;

   sensor_alarm_ctrl #(
      .NUM_CH   (NUM_CH),
      .DEBOUNCE (DEBOUNCE),
      .HOLD     (HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .sensor    (sensor),
      .ack       (ack),
      .buzzer    (buzzer),
      .active    (active),
      .alarm_id  (alarm_id),
      .alarm_cnt (alarm_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Advance the model by one rising edge with the given inputs.
   task automatic model_edge(input logic [NUM_CH-1:0] s, input logic a,
                             input logic e, input logic r);
      int c;
      if (!r) begin
         m_run = 0; m_last = 0; m_alarm = 1'b0; m_left = 0; m_ch = 0; m_cnt = 0;
      end else if (e) begin
         if (!m_alarm) begin
            c = -1;
            for (int i = 0; i < NUM_CH; i++)
               if (s[i] && c < 0) c = i;
            if (c < 0) begin
               m_run = 0;
            end else if (c == m_last && m_run != 0) begin
               m_run++;
            end else begin
               m_last = c;
               m_run  = 1;
            end
            if (m_run == DEBOUNCE) begin
               m_alarm = 1'b1;
               m_ch    = c;
               m_left  = HOLD;
               m_run   = 0;
               if (m_cnt < 255) m_cnt++;
            end
         end else begin
            if (a) begin
               m_alarm = 1'b0;
`ifdef ALARM_RETRIGGER_EN
            end else if (s[m_ch]) begin
               m_left = HOLD;
`endif
            end else begin
               m_left--;
               if (m_left == 0) m_alarm = 1'b0;
            end
         end
      end
   endtask

   // Drive one cycle of stimulus and queue the expected response.
   task automatic step(input logic [NUM_CH-1:0] s, input logic a,
                       input logic e, input logic r);
      exp_t x;
      @(negedge clk);
      sensor = s; ack = a; ena = e; rst_n = r;
      model_edge(s, a, e, r);
      x.buzzer    = m_alarm ? NUM_CH'(1 << m_ch) : '0;
      x.active    = m_alarm;
      x.alarm_id  = ID_W'(m_ch);
      x.alarm_cnt = 8'(m_cnt);
      exp_q.push_back(x);
   endtask

   task automatic run(input int n, input logic [NUM_CH-1:0] s, input logic a);
      for (int i = 0; i < n; i++) step(s, a, 1'b1, 1'b1);
   endtask

   // Monitor: compare every registered output shortly after each edge.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         check("buzzer",    32'(buzzer),    32'(x.buzzer));
         check("active",    32'(active),    32'(x.active));
         check("alarm_id",  32'(alarm_id),  32'(x.alarm_id));
         check("alarm_cnt", 32'(alarm_cnt), 32'(x.alarm_cnt));
      end
   end

   initial begin
      logic [NUM_CH-1:0] s_rand;
      int budget;
      sensor = '0; ack = 1'b0; ena = 1'b1; rst_n = 1'b0;

      // Reset state.
      step(3'b000, 1'b0, 1'b1, 1'b0);
      step(3'b000, 1'b0, 1'b1, 1'b0);

      // Basic alarm on channel 1, then let it time out.
      run(16, 3'b010, 1'b0);
      run(4, 3'b000, 1'b0);

      // Priority change restarts the debounce.
      run(2, 3'b100, 1'b0);
      run(14, 3'b101, 1'b0);
      run(3, 3'b000, 1'b0);

      // Glitch of one zero sample clears the count.
      run(3, 3'b001, 1'b0);
      run(1, 3'b000, 1'b0);
      run(6, 3'b001, 1'b0);
      run(10, 3'b000, 1'b0);

      // Ack on the third edge of an alarm.
      run(4, 3'b001, 1'b0);
      run(2, 3'b000, 1'b0);
      run(1, 3'b000, 1'b1);
      run(3, 3'b000, 1'b0);

      // Enable low for five cycles in the middle of an alarm.
      run(4, 3'b100, 1'b0);
      run(2, 3'b000, 1'b0);
      for (int i = 0; i < 5; i++) step(3'b111, 1'b1, 1'b0, 1'b1);
      run(8, 3'b000, 1'b0);

      // Reset while disabled in the middle of an alarm.
      run(6, 3'b010, 1'b0);
      step(3'b010, 1'b0, 1'b0, 1'b0);
      run(3, 3'b000, 1'b0);

      // Sensor held throughout an alarm (retrigger behaviour if enabled).
      run(20, 3'b001, 1'b0);
      run(12, 3'b000, 1'b0);

      // Saturation: 257 alarms, each ended by ack one edge after it rises.
      run(257 * 5 + 2, 3'b001, 1'b1);
      run(4, 3'b000, 1'b0);

      // Randomised traffic.
      s_rand = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) s_rand = NUM_CH'($urandom_range(0, 7));
         step(s_rand,
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 499) != 0));
      end
      run(3, 3'b000, 1'b0);

      // Let the monitor drain the scoreboard, bounded.
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sensor_alarm_ctrl.md
# sensor_alarm_ctrl

Parametrised N-channel sensor alarm controller: debounces a bank of priority-encoded sensor inputs, asserts a one-hot buzzer output for a fixed hold time once a sensor has been stable for a programmable number of cycles, and supports early acknowledge plus an alarm event counter. It sits directly behind the chip-level `ui_in` sensor pins and drives the buzzer pins on `uo_out`, under the global `ena` gate.

## Interface
- `NUM_CH`, 3: number of sensor/buzzer channels, 1..8.
- `DEBOUNCE`, 100: consecutive samples of the same winning sensor required to raise an alarm, ≥1.
- `HOLD`, 100000000: enabled cycles the buzzer stays high, ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  clock enable; low freezes all state (reset still acts).
- `sensor`  in  NUM_CH  raw sensor levels; bit 0 highest priority.
- `ack`  in  1  acknowledge; ends an active alarm early.
- `buzzer`  out  NUM_CH  one-hot alarm outputs, registered.
- `active`  out  1  high while any buzzer is high.
- `alarm_id`  out  max(1,clog2(NUM_CH))  index of the alarming channel; valid when `active`.
- `alarm_cnt`  out  8  saturating count of alarms raised.

## Operation
- Reset (`rst_n`=0 at an edge, regardless of `ena`): state IDLE; `buzzer`=0, `active`=0, `alarm_id`=0, `alarm_cnt`=0, debounce count 0, candidate 0, hold count 0.
- `ena`=0: no register changes; inputs ignored.
- Candidate: lowest-index set bit of `sensor`; none if `sensor`=0.
- IDLE, each enabled edge:
  - No candidate: debounce count ← 0.
  - Candidate c equal to stored candidate and count ≠ 0: count ← count+1.
  - Otherwise: stored candidate ← c, count ← 1.
  - If the updated count equals `DEBOUNCE`: go ALARM; `buzzer` ← one-hot(c), `alarm_id` ← c, hold count ← 0, debounce count ← 0, `alarm_cnt` ← min(`alarm_cnt`+1, 255).
  - `ack` ignored.
- ALARM, each enabled edge, first match wins:
  - `ack`=1: `buzzer` ← 0, go IDLE.
  - Hold count == `HOLD`−1: `buzzer` ← 0, go IDLE.
  - Otherwise: hold count ← hold count+1.
  - `sensor` ignored (see Configuration).
- `active` = OR of `buzzer` (registered, same edge as `buzzer`).
- Widths: debounce counter clog2(`DEBOUNCE`+1) bits, hold counter max(1,clog2(`HOLD`)) bits; neither wraps.
- On return to IDLE the debounce count is 0. A sensor still held needs a fresh `DEBOUNCE` samples; the first IDLE edge counts as sample 1.

## Timing
- Alarm latency: with candidate stable from edge k, `buzzer` is high after edge k+`DEBOUNCE`−1. `DEBOUNCE`=1 gives an alarm on the first sampling edge.
- Alarm duration without `ack`: exactly `HOLD` enabled edges. Disabled cycles stretch it in wall-clock time.
- `ack` sampled high at an edge in ALARM: `buzzer` low after that edge.
- Simultaneous `ack` and timeout: single return to IDLE, no difference.
- Candidate change mid-debounce, including a higher-priority sensor rising: count restarts at 1 for the new channel.
- Any edge with `sensor`=0 during debounce clears the count.
- Reset mid-alarm: outputs 0 after that edge; `alarm_cnt` cleared.

## Configuration
- `ALARM_RETRIGGER_EN` defined: in ALARM, if `sensor[alarm_id]` is sampled high and `ack`=0, hold count ← 0 (alarm extended). This takes precedence over timeout. Retrigger does not increment `alarm_cnt`. Other channels remain ignored.
- Not defined: `sensor` fully ignored in ALARM; duration fixed at `HOLD` unless `ack`.

## Test plan
Parameters: `NUM_CH`=3, `DEBOUNCE`=4, `HOLD`=8, `ena`=1 unless stated.
- Basic alarm: `sensor`=3'b010 held from edge 0 → `buzzer`=3'b010, `alarm_id`=1, `active`=1 after edge 3; `buzzer`=0 after edge 11; `alarm_cnt`=1.
- Priority and restart: `sensor`=3'b100 for 2 edges, then 3'b101 → no alarm until 4 edges after the change; `buzzer`=3'b001.
- Glitch: `sensor`=3'b001 for 3 edges, 0 for 1 edge, then 3'b001 → alarm 4 edges after the return, not earlier.
- Ack and freeze:
  - `ack` pulsed at the 3rd edge of an alarm → `buzzer`=0 after that edge.
  - Separately, `ena`=0 for 5 cycles mid-alarm → alarm lasts 8 enabled edges.
  - `rst_n`=0 with `ena`=0 → all outputs 0.
- Saturation: raise 257 alarms → `alarm_cnt`=255.
- `ALARM_RETRIGGER_EN`: hold `sensor`=3'b001 throughout an alarm → `buzzer` stays high until `sensor` drops, then 8 more edges; `alarm_cnt` increments once. Without the macro, `buzzer` falls after 8 edges.
